tm1637_display_arbiter: RTL and testbench
=========================================

// Module: tm1637_display_arbiter
// PURPOSE
//  Shares the single TM1637 4-digit display among N_REQ game requesters (e.g. 0=strike/alarm, 1=stage, 2=countdown).
//  Fixed-priority arbiter with a minimum hold time, so the display does not flicker, and optional per-requester blink.
//  Drives the n1..n4 digit inputs of tm1637_driver, which free-runs its refresh loop and has no handshake.
// PARAMETERS
//  N_REQ     3           number of requesters; index 0 = highest priority
//  CLK_HZ    50_000_000  clk frequency
//  HOLD_MS   250         minimum time a grant is held; HOLD_CYC = CLK_HZ/1000*HOLD_MS (>=1)
//  BLINK_MS  250         blink half-period; BLINK_CYC = CLK_HZ/1000*BLINK_MS (>=1)
// PORTS
//  clk        in   1          system clock (50 MHz)
//  rst        in   1          synchronous, active-high reset
//  req        in   N_REQ      level request per requester
//  req_digits in   12*N_REQ   requester i digits at [12i+11:12i] = {d1,d2,d3,d4}, 3 bits each; 0=blank, 1..4 shown
//  req_blink  in   N_REQ      1 = blink owner's digits while granted
//  n1..n4     out  3 each     digit codes to tm1637_driver (registered)
//  grant      out  N_REQ      one-hot current owner; all-zero = idle (registered)
//  grant_chg  out  1          1-cycle pulse on the cycle grant changes
// BEHAVIOUR
//  Reset: state=IDLE, grant=0, n1..n4=0 (blank), grant_chg=0, hold and blink counters=0. Reset mid-operation
//    takes effect on the next edge and aborts any hold.
//  All outputs are registered. A decision made from the inputs in cycle t is visible at edge t+1 (1-cycle latency).
//  Winner = lowest index i with req[i]=1.
//  FSM:
//   IDLE: no req -> stay, outputs blank. Any req -> HOLD. Load grant=winner, hold_cnt=HOLD_CYC-1, blink_cnt=0,
//     phase=ON, pulse grant_chg.
//   HOLD: hold_cnt decrements each cycle. Owner digits pass live (counter updates show). Requests from others,
//     including higher priority, are ignored.
//     If the owner drops req, its last digits are frozen into a snapshot register and shown until hold_cnt==0.
//     hold_cnt==0 -> OPEN.
//   OPEN: arbitrate every cycle.
//     Winner == owner, and owner still requesting -> stay OPEN, live digits.
//     Winner != owner (higher-priority preempt, or owner dropped and another is requesting) -> HOLD with new grant.
//     No req -> IDLE, blank at the next edge, grant=0, pulse grant_chg.
//  Blink: if req_blink[owner]=1, phase toggles every BLINK_CYC cycles. In the OFF phase n1..n4=0. Each new grant
//    starts in the ON phase. If req_blink[owner]=0, phase is forced to ON.
//  Simultaneous events:
//    hold expiry and a higher-priority req in the same cycle -> go straight from HOLD into HOLD with the new grant
//      (no OPEN cycle).
//    owner drop and another req in the same OPEN cycle -> regrant, never idle.
//  Digit codes 5..7 are passed through unchanged; the driver blanks them.
//  Counters are sized $clog2(HOLD_CYC+1) and $clog2(BLINK_CYC+1). They never wrap: each counter is reloaded
//    before it reaches 0-1.
// STRUCTURE
//  Shared package display_pkg: DIG_BLANK=3'd0, DIGIT_W=3, FRAME_W=12, and the {d1,d2,d3,d4} frame
//    packing/unpacking macros, used by both this block and tm1637_driver.
//  One sub-module: display_blink_gen (BLINK_CYC counter plus phase flop; restart input, phase output).
//  Arbitration is a priority-encoder function inside this module.
// TESTING (CLK_HZ=1000, HOLD_MS=4 -> HOLD_CYC=4, BLINK_MS=2 -> BLINK_CYC=2, N_REQ=3)
//  1 Reset/idle: rst held 3 cycles, req=0 -> grant=000, n1..n4=0, grant_chg=0 throughout.
//  2 Single req: req=100, req2 digits={1,2,3,4} at cycle t -> edge t+1: grant=100, n=1,2,3,4, grant_chg=1 for 1 cycle.
//  3 Hold vs preempt: req2 granted at t, req0 raised at t+1 -> grant stays 100 through t+4, becomes 001 at t+5.
//  4 Early drop: req1 granted with {4,3,2,1}, req1 dropped after 1 cycle -> {4,3,2,1} held to end of hold, then idle
//    and blank.
//  5 Blink: req0 with blink=1, digits {2,2,2,2} -> n toggles 2,2,0,0,2,2... starting ON at grant.
//  6 Reset mid-hold: rst pulsed during HOLD -> next edge grant=000, n=0; after release, rearbitration from IDLE.

Source files
------------

// File: rtl/display_pkg.sv
// Shared TM1637 display definitions: digit/frame widths, the blank code, the {d1,d2,d3,d4}
// frame pack/unpack helpers, and the arbiter state encoding.
package display_pkg;

    localparam int DIGIT_W = 3;
    localparam int FRAME_W = 4 * DIGIT_W;

    localparam logic [DIGIT_W-1:0] DIG_BLANK   = 3'd0;
    localparam logic [FRAME_W-1:0] FRAME_BLANK = {4{DIG_BLANK}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_OPEN = 2'd2
    } arb_state_t;

    // d1 occupies the most-significant digit slot.
    function automatic logic [FRAME_W-1:0] frame_pack(
        input logic [DIGIT_W-1:0] d1,
        input logic [DIGIT_W-1:0] d2,
        input logic [DIGIT_W-1:0] d3,
        input logic [DIGIT_W-1:0] d4
    );
        return {d1, d2, d3, d4};
    endfunction

    // pos is 1..4, matching the n1..n4 naming of the driver.
    function automatic logic [DIGIT_W-1:0] frame_digit(
        input logic [FRAME_W-1:0] frame,
        input int                 pos
    );
        return frame[FRAME_W - DIGIT_W*pos +: DIGIT_W];
    endfunction

endpackage

// File: rtl/display_blink_gen.sv
// Blink phase generator: BLINK_CYC-cycle counter plus phase flop.
// The phase output is the value the flop takes at the coming edge, so a registered frame can be gated with it.
module display_blink_gen #(
    parameter int BLINK_CYC = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    input  logic enable,
    output logic phase
);

    localparam int CNT_W = $clog2(BLINK_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_CYC - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             phase_q;
    logic             phase_d;

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        // A new grant, or an owner that does not blink, pins the phase to ON.
        if (restart || !enable) begin
            cnt_d   = '0;
            phase_d = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d   = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            phase_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase = phase_d;

endmodule

// File: rtl/tm1637_display_arbiter.sv
// Fixed-priority arbiter sharing one TM1637 display among N_REQ requesters, with a minimum
// grant hold time, a snapshot of the owner's last digits after it drops, and optional blink.
module tm1637_display_arbiter
    import display_pkg::*;
#(
    parameter int N_REQ    = 3,
    parameter int CLK_HZ   = 50_000_000,
    parameter int HOLD_MS  = 250,
    parameter int BLINK_MS = 250
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req,
    input  logic [FRAME_W*N_REQ-1:0]   req_digits,
    input  logic [N_REQ-1:0]           req_blink,
    output logic [DIGIT_W-1:0]         n1,
    output logic [DIGIT_W-1:0]         n2,
    output logic [DIGIT_W-1:0]         n3,
    output logic [DIGIT_W-1:0]         n4,
    output logic [N_REQ-1:0]           grant,
    output logic                       grant_chg
);

    localparam int HOLD_RAW  = CLK_HZ / 1000 * HOLD_MS;
    localparam int BLINK_RAW = CLK_HZ / 1000 * BLINK_MS;
    localparam int HOLD_CYC  = (HOLD_RAW  < 1) ? 1 : HOLD_RAW;
    localparam int BLINK_CYC = (BLINK_RAW < 1) ? 1 : BLINK_RAW;
    localparam int HOLD_W    = $clog2(HOLD_CYC + 1);
    localparam int OWN_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYC - 1);

    function automatic logic [OWN_W-1:0] pri_enc(input logic [N_REQ-1:0] r);
        logic [OWN_W-1:0] idx;
        idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (r[i]) idx = OWN_W'(i);
        end
        return idx;
    endfunction

    arb_state_t         state_q, state_d;
    logic [OWN_W-1:0]   owner_q, owner_d;
    logic [N_REQ-1:0]   grant_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [FRAME_W-1:0] disp_q, disp_d;
    logic [FRAME_W-1:0] snap_q, snap_d;
    logic               chg_d;

    logic [FRAME_W-1:0] frames [N_REQ];
    logic [FRAME_W-1:0] live;
    logic [FRAME_W-1:0] shown;
    logic [OWN_W-1:0]   win;
    logic               any_req;
    logic               arb_now;
    logic               new_grant;
    logic               blink_en;
    logic               phase;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            frames[i] = req_digits[i*FRAME_W +: FRAME_W];
        end
    end

    // The hold-expiry cycle arbitrates exactly like OPEN, so a preempt there goes straight to a new HOLD.
    assign any_req   = |req;
    assign win       = pri_enc(req);
    assign arb_now   = (state_q == ST_OPEN) || ((state_q == ST_HOLD) && (hold_q == '0));
    assign new_grant = any_req && ((state_q == ST_IDLE) || (arb_now && (win != owner_q)));
    assign blink_en  = (state_q != ST_IDLE) && req_blink[owner_q];

    assign live  = frames[owner_q];
    assign shown = req[owner_q] ? live : snap_q;

    display_blink_gen #(
        .BLINK_CYC (BLINK_CYC)
    ) u_blink (
        .clk     (clk),
        .rst     (rst),
        .restart (new_grant),
        .enable  (blink_en),
        .phase   (phase)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        grant_d = grant;
        hold_d  = hold_q;
        snap_d  = req[owner_q] ? live : snap_q;
        disp_d  = FRAME_BLANK;
        chg_d   = 1'b0;

        if (new_grant) begin
            state_d = ST_HOLD;
            owner_d = win;
            grant_d = N_REQ'(1) << win;
            hold_d  = HOLD_LOAD;
            snap_d  = frames[win];
            disp_d  = frames[win];
            chg_d   = 1'b1;
        end else if (arb_now) begin
            if (!any_req) begin
                state_d = ST_IDLE;
                grant_d = '0;
                chg_d   = 1'b1;
            end else begin
                state_d = ST_OPEN;
                disp_d  = phase ? live : FRAME_BLANK;
            end
        end else if (state_q == ST_HOLD) begin
            hold_d = hold_q - 1'b1;
            disp_d = phase ? shown : FRAME_BLANK;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            owner_q   <= '0;
            grant     <= '0;
            hold_q    <= '0;
            disp_q    <= FRAME_BLANK;
            grant_chg <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            grant     <= grant_d;
            hold_q    <= hold_d;
            disp_q    <= disp_d;
            grant_chg <= chg_d;
        end
    end

    always_ff @(posedge clk) begin
        snap_q <= snap_d;
    end

    assign n1 = frame_digit(disp_q, 1);
    assign n2 = frame_digit(disp_q, 2);
    assign n3 = frame_digit(disp_q, 3);
    assign n4 = frame_digit(disp_q, 4);

endmodule

// File: tb/tb_tm1637_display_arbiter.sv
// Directed bench for tm1637_display_arbiter with CLK_HZ=1000, HOLD_MS=4, BLINK_MS=2, N_REQ=3.
module tb_tm1637_display_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req;
    logic [35:0] req_digits;
    logic [2:0]  req_blink;
    logic [2:0]  n1, n2, n3, n4;
    logic [2:0]  grant;
    logic        grant_chg;

    int n_checks = 0;
    int n_fail   = 0;

    tm1637_display_arbiter #(
        .N_REQ    (3),
        .CLK_HZ   (1000),
        .HOLD_MS  (4),
        .BLINK_MS (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_digits (req_digits),
        .req_blink  (req_blink),
        .n1         (n1),
        .n2         (n2),
        .n3         (n3),
        .n4         (n4),
        .grant      (grant),
        .grant_chg  (grant_chg)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] fr(input int a, input int b, input int c, input int d);
        logic [2:0] da, db, dc, dd;
        da = a[2:0]; db = b[2:0]; dc = c[2:0]; dd = d[2:0];
        return {da, db, dc, dd};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_dig(input int i, input logic [11:0] f);
        req_digits[i*12 +: 12] = f;
    endtask

    task automatic check_out(input string tag, input logic [2:0] g, input logic [11:0] f, input logic c);
        chk({tag, "_grant"}, int'(grant), int'(g));
        chk({tag, "_digits"}, int'({n1, n2, n3, n4}), int'(f));
        chk({tag, "_chg"}, int'(grant_chg), int'(c));
    endtask

    logic [11:0] blink_exp [7];

    initial begin
        rst        = 1'b1;
        req        = 3'b000;
        req_blink  = 3'b000;
        req_digits = '0;

        // Reset and idle
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out("reset", 3'b000, 12'd0, 1'b0);
        end
        rst = 1'b0;
        tick();
        check_out("idle", 3'b000, 12'd0, 1'b0);

        // Single request, live update during hold, then preempt after hold expiry
        set_dig(2, fr(1, 2, 3, 4));
        req = 3'b100;
        tick();
        check_out("single", 3'b100, fr(1, 2, 3, 4), 1'b1);
        req = 3'b101;
        set_dig(0, fr(3, 3, 3, 3));
        tick();
        check_out("hold_e2", 3'b100, fr(1, 2, 3, 4), 1'b0);
        set_dig(2, fr(1, 1, 1, 1));
        tick();
        check_out("live_e3", 3'b100, fr(1, 1, 1, 1), 1'b0);
        tick();
        check_out("hold_e4", 3'b100, fr(1, 1, 1, 1), 1'b0);
        tick();
        check_out("preempt", 3'b001, fr(3, 3, 3, 3), 1'b1);

        // Owner drops immediately: snapshot shown for the rest of the hold
        req = 3'b000;
        set_dig(0, fr(0, 0, 0, 0));
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out("snap0", 3'b001, fr(3, 3, 3, 3), 1'b0);
        end
        tick();
        check_out("idle0", 3'b000, 12'd0, 1'b1);
        tick();
        check_out("idle0b", 3'b000, 12'd0, 1'b0);

        // Early drop after one cycle
        set_dig(1, fr(4, 3, 2, 1));
        req = 3'b010;
        tick();
        check_out("drop_g", 3'b010, fr(4, 3, 2, 1), 1'b1);
        tick();
        check_out("drop_e2", 3'b010, fr(4, 3, 2, 1), 1'b0);
        req = 3'b000;
        set_dig(1, fr(5, 6, 7, 5));
        for (int i = 0; i < 2; i++) begin
            tick();
            check_out("drop_snap", 3'b010, fr(4, 3, 2, 1), 1'b0);
        end
        tick();
        check_out("drop_idle", 3'b000, 12'd0, 1'b1);

        // Hold expiry into OPEN, codes 5..7 pass through, then drop-with-other regrant
        set_dig(1, fr(7, 6, 5, 0));
        req = 3'b010;
        tick();
        check_out("open_g", 3'b010, fr(7, 6, 5, 0), 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out("open_hold", 3'b010, fr(7, 6, 5, 0), 1'b0);
        end
        tick();
        check_out("open_e5", 3'b010, fr(7, 6, 5, 0), 1'b0);
        set_dig(1, fr(1, 2, 3, 4));
        tick();
        check_out("open_live", 3'b010, fr(1, 2, 3, 4), 1'b0);
        req = 3'b100;
        set_dig(2, fr(2, 3, 4, 1));
        tick();
        check_out("regrant", 3'b100, fr(2, 3, 4, 1), 1'b1);

        // Reset pulsed mid-hold, then rearbitration from idle
        rst = 1'b1;
        tick();
        check_out("rst_mid", 3'b000, 12'd0, 1'b0);
        rst = 1'b0;
        tick();
        check_out("rearb", 3'b100, fr(2, 3, 4, 1), 1'b1);
        req = 3'b000;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out("rearb_hold", 3'b100, fr(2, 3, 4, 1), 1'b0);
        end
        tick();
        check_out("rearb_idle", 3'b000, 12'd0, 1'b1);

        // Blink: 2,2,0,0,2,2,0 from the grant edge, then blink off forces ON
        blink_exp[0] = fr(2, 2, 2, 2);
        blink_exp[1] = fr(2, 2, 2, 2);
        blink_exp[2] = 12'd0;
        blink_exp[3] = 12'd0;
        blink_exp[4] = fr(2, 2, 2, 2);
        blink_exp[5] = fr(2, 2, 2, 2);
        blink_exp[6] = 12'd0;
        set_dig(0, fr(2, 2, 2, 2));
        req_blink = 3'b001;
        req       = 3'b001;
        for (int i = 0; i < 7; i++) begin
            tick();
            check_out("blink", 3'b001, blink_exp[i], (i == 0) ? 1'b1 : 1'b0);
        end
        req_blink = 3'b000;
        tick();
        check_out("blink_off", 3'b001, fr(2, 2, 2, 2), 1'b0);
        req = 3'b000;
        tick();
        check_out("blink_idle", 3'b000, 12'd0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
